// File: rtl/ai_paddle_controller_pkg.sv
// Shared display geometry, game-state encoding and AI opponent state type.
// Imported by the paddle controllers and the ball controller.
package ai_paddle_controller_pkg;

   localparam int HOR_PIXELS    = 800;
   localparam int VER_PIXELS    = 600;
   localparam int BALL_SIZE     = 16;
   // Shared with the ball controller so its hit window matches the drawn paddle
   localparam int AI_PAD_HEIGHT = 145;

   typedef enum logic [1:0] {
      GS_MENU  = 2'd0,
      GS_PLAY  = 2'd1,
      GS_POINT = 2'd2,
      GS_OVER  = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CENTER = 2'd1,
      REACT  = 2'd2,
      TRACK  = 2'd3
   } ai_state_t;

   function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
      return (v < 12'sd0) ? -v : v;
   endfunction

endpackage

// File: rtl/ai_paddle_controller_if.sv
// Ball-to-paddle bus: the ball side drives position/tick/state and reads back
// the AI paddle position.
interface ai_paddle_controller_if;

   logic        timing_tick;
   logic [1:0]  state;
   logic [10:0] x_ball;
   logic [9:0]  y_ball;
   logic [9:0]  y_pad;
   logic        ai_tracking;

   modport master (
      output timing_tick, state, x_ball, y_ball,
      input  y_pad, ai_tracking
   );

   modport slave (
      input  timing_tick, state, x_ball, y_ball,
      output y_pad, ai_tracking
   );

endinterface

// File: rtl/ai_paddle_controller_pad_stepper.sv
// One movement step of a paddle toward a goal: goal clamped to the playfield,
// dead zone around the goal, displacement limited to MAX_STEP.
module ai_paddle_controller_pad_stepper #(
   parameter int MAX_STEP  = 4,
   parameter int DEAD_ZONE = 8,
   parameter int POS_MAX   = 455
) (
   input  logic        [9:0]  i_cur,
   input  logic signed [11:0] i_goal,
   output logic        [9:0]  o_next
);
   import ai_paddle_controller_pkg::*;

   localparam logic signed [11:0] LIM  = 12'(POS_MAX);
   localparam logic signed [11:0] STEP = 12'(MAX_STEP);
   localparam logic signed [11:0] DZ   = 12'(DEAD_ZONE);

   logic signed [11:0] w_goal_c;
   logic signed [11:0] w_cur;
   logic signed [11:0] w_diff;
   logic signed [11:0] w_mag;
   logic signed [11:0] w_step;
   logic signed [11:0] w_sum;

   always_comb begin
      if (i_goal < 12'sd0)
         w_goal_c = 12'sd0;
      else if (i_goal > LIM)
         w_goal_c = LIM;
      else
         w_goal_c = i_goal;

      w_cur  = $signed({2'b00, i_cur});
      w_diff = w_goal_c - w_cur;
      w_mag  = abs12(w_diff);
      w_step = (w_mag > STEP) ? STEP : w_mag;

      // Step never exceeds |diff|, so a clamped goal keeps the result in range
      if (w_mag <= DZ)
         w_sum = w_cur;
      else if (w_diff < 12'sd0)
         w_sum = w_cur - w_step;
      else
         w_sum = w_cur + w_step;

      o_next = 10'(w_sum);
   end

endmodule

// File: rtl/ai_paddle_controller.sv
// Computer opponent paddle: watches ball direction, waits a reaction delay,
// then tracks the ball centre; re-centres when the ball recedes or is served.
module ai_paddle_controller
   import ai_paddle_controller_pkg::*;
#(
   parameter int SIDE        = 1,
   parameter int PAD_HEIGHT  = AI_PAD_HEIGHT,
   parameter int MAX_STEP    = 4,
   parameter int DEAD_ZONE   = 8,
   parameter int REACT_TICKS = 6,
   parameter int JUMP_LIMIT  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ai_paddle_controller_if.slave   bus
);

   localparam int               POS_MAX   = VER_PIXELS - PAD_HEIGHT;
   localparam logic [9:0]       Y_CENTER  = 10'(POS_MAX / 2);
   localparam int               CNT_W     = $clog2(REACT_TICKS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REACT_TICKS - 1);
   localparam logic signed [11:0] JUMP_S    = 12'(JUMP_LIMIT);
   localparam logic signed [11:0] BALL_HALF = 12'(BALL_SIZE / 2);
   localparam logic signed [11:0] PAD_HALF  = 12'(PAD_HEIGHT / 2);

   ai_state_t        r_state;
   ai_state_t        w_state_nxt;
   logic [9:0]       r_y_pad;
   logic [9:0]       w_y_nxt;
   logic             r_ai_tracking;
   logic [10:0]      r_x_prev;
   logic [CNT_W-1:0] r_react_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_approach;

   logic signed [11:0] w_dx;
   logic               w_serve;
   logic               w_approach_nxt;
   logic signed [11:0] w_target;
   logic signed [11:0] w_goal;
   logic [9:0]         w_step_y;
   logic               w_play;

   assign w_play   = (bus.state == GS_PLAY);
   assign w_dx     = $signed({1'b0, bus.x_ball}) - $signed({1'b0, r_x_prev});
   assign w_serve  = (abs12(w_dx) > JUMP_S);
   assign w_target = $signed({2'b00, bus.y_ball}) + BALL_HALF - PAD_HALF;
   assign w_goal   = (r_state == TRACK) ? w_target : $signed({2'b00, Y_CENTER});

   // A serve jump is not a direction change, so it leaves the approach flag alone
   always_comb begin
      w_approach_nxt = r_approach;
      if (!w_serve && (w_dx != 12'sd0))
         w_approach_nxt = (SIDE != 0) ? (w_dx > 12'sd0) : (w_dx < 12'sd0);
   end

   ai_paddle_controller_pad_stepper #(
      .MAX_STEP  (MAX_STEP),
      .DEAD_ZONE (DEAD_ZONE),
      .POS_MAX   (POS_MAX)
   ) u_stepper (
      .i_cur  (r_y_pad),
      .i_goal (w_goal),
      .o_next (w_step_y)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = r_y_pad;
      w_cnt_nxt   = r_react_cnt;
      unique case (r_state)
         IDLE: w_state_nxt = CENTER;
         CENTER: begin
            w_y_nxt = w_step_y;
            if (w_approach_nxt && !w_serve) begin
               w_cnt_nxt   = '0;
               w_state_nxt = REACT;
            end
         end
         REACT: begin
            w_cnt_nxt = r_react_cnt + 1'b1;
            if (!w_approach_nxt || w_serve)
               w_state_nxt = CENTER;
            else if (r_react_cnt == CNT_LAST)
               w_state_nxt = TRACK;
         end
         TRACK: begin
            w_y_nxt = w_step_y;
            if (!w_approach_nxt || w_serve)
               w_state_nxt = CENTER;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Leaving PLAY overrides the tick gating and parks the paddle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_y_pad       <= Y_CENTER;
         r_ai_tracking <= 1'b0;
         r_x_prev      <= '0;
         r_react_cnt   <= '0;
         r_approach    <= 1'b0;
      end else if (!w_play) begin
         r_state       <= IDLE;
         r_y_pad       <= Y_CENTER;
         r_ai_tracking <= 1'b0;
         r_x_prev      <= bus.x_ball;
         r_react_cnt   <= '0;
      end else if (bus.timing_tick) begin
         r_state       <= w_state_nxt;
         r_y_pad       <= w_y_nxt;
         r_ai_tracking <= (w_state_nxt == TRACK);
         r_x_prev      <= bus.x_ball;
         r_react_cnt   <= w_cnt_nxt;
         r_approach    <= w_approach_nxt;
      end
   end

   assign bus.y_pad       = r_y_pad;
   assign bus.ai_tracking = r_ai_tracking;

endmodule
